// File: rtl/lsu_if.sv
// Core-side and data-memory-side bundles for the load/store unit.
// Core: master = pipeline, slave = lsu. Dmem: master = lsu, slave = memory.
interface lsu_core_if #(parameter int ADDR_W = 32);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic              wren_i;
  logic [2:0]        mem_op_i;
  logic              rsp_valid_o;
  logic [31:0]       rdata_o;
  logic              err_o;

  modport master (output req_valid_i, addr_i, wdata_i, wren_i, mem_op_i,
                  input  req_ready_o, rsp_valid_o, rdata_o, err_o);
  modport slave  (input  req_valid_i, addr_i, wdata_i, wren_i, mem_op_i,
                  output req_ready_o, rsp_valid_o, rdata_o, err_o);
endinterface

interface lsu_dmem_if #(parameter int ADDR_W = 32);
  logic              dmem_req_o;
  logic              dmem_gnt_i;
  logic              dmem_we_o;
  logic [ADDR_W-1:0] dmem_addr_o;
  logic [3:0]        dmem_be_o;
  logic [31:0]       dmem_wdata_o;
  logic              dmem_rvalid_i;
  logic [31:0]       dmem_rdata_i;

  modport master (output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                  input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i);
  modport slave  (input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                  output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i);
endinterface

// File: rtl/lsu.sv
// Load/store unit: byte/half/word accesses over a req/gnt/rvalid bus with
// alignment trapping and sign/zero extension of load data.
//
// state | meaning
// IDLE  | ready for a request; illegal ops skip straight to RESP
// REQ   | bus request held with frozen fields until grant
// WAIT  | load granted, waiting for rvalid
// RESP  | one-cycle completion pulse with rdata/err
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  lsu_core_if.slave   core,
  lsu_dmem_if.master  dmem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_wren;
  logic [2:0]        r_op;
  logic              r_err;
  logic [31:0]       r_rdata;

  logic              w_accept;
  logic              w_illegal;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [7:0]        w_lane;
  logic [15:0]       w_half;
  logic [31:0]       w_load;

  assign w_accept = (r_state == S_IDLE) && core.req_valid_i;

  always_comb begin
    w_illegal = 1'b0;
    case (core.mem_op_i)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = core.addr_i[0];
      3'b010:  w_illegal = (core.addr_i[1:0] != 2'b00);
      3'b100:  w_illegal = core.wren_i;
      3'b101:  w_illegal = core.wren_i | core.addr_i[0];
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (core.req_valid_i) w_next = w_illegal ? S_RESP : S_REQ;
      S_REQ:   if (dmem.dmem_gnt_i) w_next = r_wren ? S_RESP : S_WAIT;
      S_WAIT:  if (dmem.dmem_rvalid_i) w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wren  <= 1'b0;
      r_op    <= 3'b000;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_addr  <= core.addr_i;
      r_wdata <= core.wdata_i;
      r_wren  <= core.wren_i;
      r_op    <= core.mem_op_i;
      r_err   <= w_illegal;
      r_rdata <= '0;
    end else if ((r_state == S_WAIT) && dmem.dmem_rvalid_i) begin
      r_rdata <= w_load;
    end
  end

  // Loads always read the full word; lanes are picked out on return.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (r_op[1:0])
      2'b00: begin
        if (r_wren) w_be = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        if (r_wren) w_be = 4'b0011 << r_addr[1:0];
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_lane = 8'h00;
    case (r_addr[1:0])
      2'b00: w_lane = dmem.dmem_rdata_i[7:0];
      2'b01: w_lane = dmem.dmem_rdata_i[15:8];
      2'b10: w_lane = dmem.dmem_rdata_i[23:16];
      2'b11: w_lane = dmem.dmem_rdata_i[31:24];
    endcase
    w_half = r_addr[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
    w_load = dmem.dmem_rdata_i;
    case (r_op)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane};
      3'b100:  w_load = {24'h000000, w_lane};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0000, w_half};
      default: w_load = dmem.dmem_rdata_i;
    endcase
  end

  always_comb begin
    core.req_ready_o  = (r_state == S_IDLE);
    core.rsp_valid_o  = (r_state == S_RESP);
    core.rdata_o      = (r_state == S_RESP) ? r_rdata : 32'h0;
    core.err_o        = (r_state == S_RESP) && r_err;
    dmem.dmem_req_o   = 1'b0;
    dmem.dmem_we_o    = 1'b0;
    dmem.dmem_addr_o  = '0;
    dmem.dmem_be_o    = 4'b0000;
    dmem.dmem_wdata_o = 32'h0;
    if (r_state == S_REQ) begin
      dmem.dmem_req_o   = 1'b1;
      dmem.dmem_we_o    = r_wren;
      dmem.dmem_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
      dmem.dmem_be_o    = w_be;
      dmem.dmem_wdata_o = w_wdata;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, traps, async reset and back-to-back traffic.
module tb_lsu;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] mem_word;

  lsu_core_if #(.ADDR_W(32)) core ();
  lsu_dmem_if #(.ADDR_W(32)) dmem ();

  lsu #(.ADDR_W(32)) dut (.clk_i(clk_i), .rst_i(rst_i), .core(core), .dmem(dmem));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request for one cycle; returns in cycle T+1.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic [2:0] op);
    core.req_valid_i = 1'b1;
    core.addr_i      = a;
    core.wdata_i     = wd;
    core.wren_i      = we;
    core.mem_op_i    = op;
    step();
    core.req_valid_i = 1'b0;
    core.addr_i      = 32'h0;
    core.wdata_i     = 32'h0;
    core.wren_i      = 1'b0;
    core.mem_op_i    = 3'b000;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] op,
                         input logic [31:0] bus, input logic [31:0] exp);
    issue(a, 32'h0, 1'b0, op);
    chk({tag, "_req"}, {31'h0, dmem.dmem_req_o}, 32'h1);
    chk({tag, "_addr"}, dmem.dmem_addr_o, {a[31:2], 2'b00});
    dmem.dmem_gnt_i = 1'b1;
    step();
    dmem.dmem_gnt_i    = 1'b0;
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = bus;
    step();
    dmem.dmem_rvalid_i = 1'b0;
    dmem.dmem_rdata_i  = 32'h0;
    chk({tag, "_rsp"}, {31'h0, core.rsp_valid_o}, 32'h1);
    chk({tag, "_rdata"}, core.rdata_o, exp);
    step();
  endtask

  task automatic do_err(input string tag, input logic [31:0] a, input logic we,
                        input logic [2:0] op);
    issue(a, 32'h1234_5678, we, op);
    chk({tag, "_rsp"}, {31'h0, core.rsp_valid_o}, 32'h1);
    chk({tag, "_err"}, {31'h0, core.err_o}, 32'h1);
    chk({tag, "_rdata"}, core.rdata_o, 32'h0);
    chk({tag, "_noreq"}, {31'h0, dmem.dmem_req_o}, 32'h0);
    step();
    chk({tag, "_idle"}, {30'h0, dmem.dmem_req_o, core.rsp_valid_o}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    core.req_valid_i   = 1'b0;
    core.addr_i        = 32'h0;
    core.wdata_i       = 32'h0;
    core.wren_i        = 1'b0;
    core.mem_op_i      = 3'b000;
    dmem.dmem_gnt_i    = 1'b0;
    dmem.dmem_rvalid_i = 1'b0;
    dmem.dmem_rdata_i  = 32'h0;
    mem_word           = 32'h0;
    step();
    step();
    chk("rst_ready", {31'h0, core.req_ready_o}, 32'h1);
    chk("rst_outs", {29'h0, core.rsp_valid_o, core.err_o, dmem.dmem_req_o}, 32'h0);
    chk("rst_rdata", core.rdata_o, 32'h0);
    chk("rst_bus", dmem.dmem_addr_o | dmem.dmem_wdata_o | {28'h0, dmem.dmem_be_o}
        | {31'h0, dmem.dmem_we_o}, 32'h0);
    #2 rst_i = 1'b0;
    step();

    // LB at 0x103, cycle-exact latency checks
    issue(32'h103, 32'h0, 1'b0, 3'b000);
    chk("lb_req", {31'h0, dmem.dmem_req_o}, 32'h1);
    chk("lb_addr", dmem.dmem_addr_o, 32'h100);
    chk("lb_be", {28'h0, dmem.dmem_be_o}, 32'hF);
    chk("lb_we", {31'h0, dmem.dmem_we_o}, 32'h0);
    chk("lb_busy", {31'h0, core.req_ready_o}, 32'h0);
    dmem.dmem_gnt_i = 1'b1;
    step();
    dmem.dmem_gnt_i = 1'b0;
    chk("lb_wait", {30'h0, dmem.dmem_req_o, core.rsp_valid_o}, 32'h0);
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = 32'h80FF_1234;
    step();
    dmem.dmem_rvalid_i = 1'b0;
    dmem.dmem_rdata_i  = 32'h0;
    chk("lb_rsp_t3", {31'h0, core.rsp_valid_o}, 32'h1);
    chk("lb_rdata", core.rdata_o, 32'hFFFF_FF80);
    chk("lb_err", {31'h0, core.err_o}, 32'h0);
    step();
    chk("lb_pulse", {31'h0, core.rsp_valid_o}, 32'h0);
    chk("lb_ready", {31'h0, core.req_ready_o}, 32'h1);

    do_load("lhu", 32'h202, 3'b101, 32'h8001_7777, 32'h0000_8001);
    do_load("lh",  32'h202, 3'b001, 32'h8001_7777, 32'hFFFF_8001);
    do_load("lh0", 32'h200, 3'b001, 32'h8001_7777, 32'h0000_7777);
    do_load("lbu", 32'h101, 3'b100, 32'h80FF_9234, 32'h0000_0092);
    do_load("lw",  32'h10C, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // SB at 0x05 with grant withheld 3 cycles; a request while busy must be ignored
    issue(32'h05, 32'h1234_56AB, 1'b1, 3'b000);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        core.req_valid_i = 1'b1;
        core.addr_i      = 32'h0000_0F00;
        core.wren_i      = 1'b0;
      end
      chk("sb_req", {31'h0, dmem.dmem_req_o}, 32'h1);
      chk("sb_we", {31'h0, dmem.dmem_we_o}, 32'h1);
      chk("sb_be", {28'h0, dmem.dmem_be_o}, 32'h2);
      chk("sb_wdata", dmem.dmem_wdata_o, 32'hABAB_ABAB);
      chk("sb_addr", dmem.dmem_addr_o, 32'h4);
      if (i == 3) dmem.dmem_gnt_i = 1'b1;
      step();
    end
    core.req_valid_i = 1'b0;
    core.addr_i      = 32'h0;
    dmem.dmem_gnt_i  = 1'b0;
    chk("sb_rsp", {31'h0, core.rsp_valid_o}, 32'h1);
    chk("sb_rdata", core.rdata_o, 32'h0);
    chk("sb_err", {31'h0, core.err_o}, 32'h0);
    step();

    // SH at 0x06: upper half lanes
    issue(32'h06, 32'h0000_BEEF, 1'b1, 3'b001);
    chk("sh_be", {28'h0, dmem.dmem_be_o}, 32'hC);
    chk("sh_wdata", dmem.dmem_wdata_o, 32'hBEEF_BEEF);
    dmem.dmem_gnt_i = 1'b1;
    step();
    dmem.dmem_gnt_i = 1'b0;
    chk("sh_rsp", {31'h0, core.rsp_valid_o}, 32'h1);
    step();

    do_err("sw_mis", 32'h102, 1'b1, 3'b010);
    do_err("lh_mis", 32'h01,  1'b0, 3'b001);
    do_err("op011",  32'h00,  1'b0, 3'b011);
    do_err("sbu",    32'h00,  1'b1, 3'b100);
    do_err("lhu_mis", 32'h03, 1'b0, 3'b101);
    do_err("op111",  32'h08,  1'b0, 3'b111);

    // Reset while REQ: request drops without waiting for a clock edge
    issue(32'h20, 32'h0, 1'b0, 3'b010);
    chk("rreq_req", {31'h0, dmem.dmem_req_o}, 32'h1);
    #2 rst_i = 1'b1;
    #1;
    chk("rreq_drop", {31'h0, dmem.dmem_req_o}, 32'h0);
    chk("rreq_addr", dmem.dmem_addr_o, 32'h0);
    step();
    #2 rst_i = 1'b0;
    dmem.dmem_gnt_i = 1'b1;
    step();
    dmem.dmem_gnt_i = 1'b0;
    chk("rreq_stale_gnt", {30'h0, dmem.dmem_req_o, core.rsp_valid_o}, 32'h0);

    // Reset while WAIT, stale rvalid afterwards, then a normal LW
    issue(32'h300, 32'h0, 1'b0, 3'b010);
    dmem.dmem_gnt_i = 1'b1;
    step();
    dmem.dmem_gnt_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("rwait_ready", {31'h0, core.req_ready_o}, 32'h1);
    chk("rwait_outs", {29'h0, core.rsp_valid_o, core.err_o, dmem.dmem_req_o}, 32'h0);
    step();
    #2 rst_i = 1'b0;
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = 32'h5555_5555;
    step();
    dmem.dmem_rvalid_i = 1'b0;
    dmem.dmem_rdata_i  = 32'h0;
    chk("rwait_stale_rv", {31'h0, core.rsp_valid_o}, 32'h0);
    step();
    chk("rwait_stale_rv2", {31'h0, core.rsp_valid_o}, 32'h0);
    do_load("rwait_lw", 32'h300, 3'b010, 32'h1122_3344, 32'h1122_3344);

    // Back-to-back SW then LW through a one-word memory model
    issue(32'h40, 32'hDEAD_BEEF, 1'b1, 3'b010);
    chk("b2b_sw_busy", {31'h0, core.req_ready_o}, 32'h0);
    chk("b2b_sw_be", {28'h0, dmem.dmem_be_o}, 32'hF);
    for (int b = 0; b < 4; b++)
      if (dmem.dmem_be_o[b] && dmem.dmem_we_o && dmem.dmem_addr_o == 32'h40)
        mem_word[8*b +: 8] = dmem.dmem_wdata_o[8*b +: 8];
    dmem.dmem_gnt_i = 1'b1;
    step();
    dmem.dmem_gnt_i = 1'b0;
    chk("b2b_sw_rsp", {31'h0, core.rsp_valid_o}, 32'h1);
    chk("b2b_resp_busy", {31'h0, core.req_ready_o}, 32'h0);
    step();
    issue(32'h40, 32'h0, 1'b0, 3'b010);
    chk("b2b_lw_busy", {31'h0, core.req_ready_o}, 32'h0);
    chk("b2b_lw_addr", dmem.dmem_addr_o, 32'h40);
    dmem.dmem_gnt_i = 1'b1;
    step();
    dmem.dmem_gnt_i = 1'b0;
    chk("b2b_wait_busy", {31'h0, core.req_ready_o}, 32'h0);
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = mem_word;
    step();
    dmem.dmem_rvalid_i = 1'b0;
    dmem.dmem_rdata_i  = 32'h0;
    chk("b2b_lw_rsp", {31'h0, core.rsp_valid_o}, 32'h1);
    chk("b2b_lw_rdata", core.rdata_o, 32'hDEAD_BEEF);
    step();
    chk("b2b_ready", {31'h0, core.req_ready_o}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the core datapath and the data-memory bus. It consumes the memory controls produced by instruction decode (`wren`, 3-bit `funct3` memory op) together with the ALU-computed address and the rs2 store data. It performs byte/half/word accesses over a req/gnt/rvalid bus and returns sign- or zero-extended load data to writeback. Misaligned and illegal accesses are trapped without issuing a bus transaction.

## Interface
- ADDR_W, 32, address width for both the core side and the bus side.

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  LSU can accept a request
- addr_i  in  ADDR_W  byte address from the ALU
- wdata_i  in  32  store data (rs2)
- wren_i  in  1  1: store, 0: load
- mem_op_i  in  3  funct3 access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rsp_valid_o  out  1  one-cycle completion pulse
- rdata_o  out  32  extended load data
- err_o  out  1  qualified by rsp_valid_o: misaligned or illegal op
- dmem_req_o  out  1  bus request
- dmem_gnt_i  in  1  bus grant
- dmem_we_o  out  1  bus write enable
- dmem_addr_o  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-aligned store data
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read data

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - req_ready_o=1.
  - On req_valid_i, latch addr, wdata, wren and op.
  - Go to RESP with err set if the access is illegal; otherwise go to REQ.
- **Illegal access:** halfword with addr[0]=1; word with addr[1:0]≠0; op ∈ {011,110,111}; store with op 100 or 101.
- **REQ**
  - dmem_req_o=1 with we/addr/be/wdata held stable until grant.
  - On dmem_gnt_i: a store goes to RESP (the write completes at grant); a load goes to WAIT.
- **WAIT**
  - Hold until dmem_rvalid_i.
  - On rvalid, capture the extracted data and go to RESP.
  - rvalid outside WAIT is ignored.
- **RESP**
  - rsp_valid_o=1 for exactly one cycle, with rdata_o and err_o valid.
  - Next state is IDLE; req_ready_o=0.
- **Byte enables**
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<addr[1:0].
  - W: 4'b1111.
- **Store data**
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata.
- **Load extraction**
  - Byte lane = dmem_rdata_i[8*addr[1:0] +: 8].
  - Halfword = dmem_rdata_i[16*addr[1] +: 16].
  - B/H sign-extend, BU/HU zero-extend, W passes through.
- rdata_o=0 for stores and for err responses.
- Bus outputs are 0 whenever not in REQ.

## Timing
- **Reset values:** state IDLE; req_ready_o=1; rsp_valid_o=0; rdata_o=0; err_o=0; all dmem_* outputs 0.
- **Reset mid-operation:** dmem_req_o drops asynchronously, the transaction is abandoned and no rsp_valid_o is produced. Stale gnt/rvalid arriving after reset are ignored.
- **Accept:** request accepted in cycle T (valid&&ready at the clock edge). dmem_req_o is asserted from T+1 and is registered, never combinational from req_valid_i.
- **Store, 0-wait grant:** gnt in T+1, rsp_valid_o in T+2.
- **Load:** gnt in T+1, rvalid earliest T+2, rsp_valid_o in the cycle after rvalid (T+3 best case).
- **Illegal access:** rsp_valid_o with err_o in T+1; no bus activity.
- **Grant timing:** grant may be withheld indefinitely; request fields stay frozen.
- **Throughput:** one outstanding transaction. The next request can be accepted in the cycle after RESP.
- **Back-to-back inputs:** inputs presented while req_ready_o=0 are not sampled.

## Test plan
- **Load byte, signed:** LB at addr 0x103 with rdata 0x80FF_1234, gnt and rvalid 0-wait.
  - dmem_addr 0x100, be 1111 read, rdata_o 0xFFFF_FF80, err_o 0.
  - rsp_valid_o at T+3.
- **Load halfword, unsigned:** LHU at addr 0x202 with rdata 0x8001_7777.
  - rdata_o 0x0000_8001.
- **Store byte with delayed grant:** SB at addr 0x05, wdata 0x1234_56AB, grant delayed 3 cycles.
  - dmem_be 0010, dmem_wdata 0xABAB_ABAB, dmem_addr 0x04, all held stable for 4 cycles.
  - rsp_valid_o 1 cycle after gnt.
- **Misaligned and illegal ops:**
  - SW at 0x102 → err_o=1 at T+1, dmem_req_o never asserted.
  - LH at 0x01 → same.
  - op 011 → same.
- **Reset during WAIT:** assert rst_i while in WAIT.
  - Outputs return to reset values immediately.
  - A subsequent rvalid produces no rsp_valid_o.
  - The next LW completes normally.
- **Back-to-back traffic:** SW 0xDEAD_BEEF at 0x40, then LW at 0x40 against a memory model.
  - Load returns 0xDEAD_BEEF.
  - req_ready_o is low from accept through RESP.
